// File: rtl/rv_mem_arbiter.sv
// Shares one synchronous word memory between the instruction-fetch port and the
// load/store port: grants one requester, drives the strobes, waits out the read latency.
module rv_mem_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  // Handshake: a requester raises req with its address/data stable and keeps it
  // high until it sees its one-cycle done pulse; it drops req on that same edge.
  // A req still high in the IDLE cycle after DONE starts a new transaction.

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  state_t     state;
  logic       last_grant;   // 1 = data port was granted most recently
  logic       grant_d;      // port owning the current transaction
  logic       is_write;
  logic [3:0] wait_cnt;
  logic       take_d;

  // On a tie the port that was not granted last wins.
  assign take_d = d_req && (!i_req || !last_grant);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_d    <= 1'b0;
      is_write   <= 1'b0;
      wait_cnt   <= 4'd0;
      i_rdata    <= 32'd0;
      d_rdata    <= 32'd0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      mem_wmask  <= 4'd0;
      mem_rstrb  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            grant_d    <= take_d;
            last_grant <= take_d;
            if (take_d) begin
              mem_addr <= d_addr;
              if (d_wmask != 4'd0) begin
                is_write  <= 1'b1;
                mem_wmask <= d_wmask;
                mem_wdata <= d_wdata;
              end else begin
                is_write  <= 1'b0;
                mem_rstrb <= 1'b1;
              end
            end else begin
              mem_addr  <= i_addr;
              is_write  <= 1'b0;
              mem_rstrb <= 1'b1;
            end
          end
        end
        ISSUE: begin
          mem_rstrb <= 1'b0;
          mem_wmask <= 4'd0;
          if (is_write) begin
            state  <= DONE;
            d_done <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          // mem_rdata is only valid at the end of the last wait cycle.
          if (wait_cnt == 4'd0) begin
            state <= DONE;
            if (grant_d) begin
              d_rdata <= mem_rdata;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_done  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          i_done <= 1'b0;
          d_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: a LATENCY=1 instance driven from a vector
// table plus hand sequences, and a LATENCY=4 instance for the long-wait case.
module tb_rv_mem_arbiter;

  localparam int AW = 30;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // LATENCY=1 instance
  logic          i_req, d_req, i_done, d_done, mem_rstrb, busy;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [3:0]    d_wmask, mem_wmask;
  logic [31:0]   d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;

  // LATENCY=4 instance
  logic          i_req_4, d_req_4, i_done_4, d_done_4, mem_rstrb_4, busy_4;
  logic [AW-1:0] i_addr_4, d_addr_4, mem_addr_4;
  logic [3:0]    d_wmask_4, mem_wmask_4;
  logic [31:0]   d_wdata_4, i_rdata_4, d_rdata_4, mem_wdata_4, mem_rdata_4;

  rv_mem_arbiter #(.ADDR_W(AW), .LATENCY(1)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .busy(busy)
  );

  rv_mem_arbiter #(.ADDR_W(AW), .LATENCY(4)) dut4 (
    .clk(clk), .resetn(resetn),
    .i_req(i_req_4), .i_addr(i_addr_4), .i_rdata(i_rdata_4), .i_done(i_done_4),
    .d_req(d_req_4), .d_addr(d_addr_4), .d_wmask(d_wmask_4), .d_wdata(d_wdata_4),
    .d_rdata(d_rdata_4), .d_done(d_done_4),
    .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4), .mem_wmask(mem_wmask_4),
    .mem_rstrb(mem_rstrb_4), .mem_rdata(mem_rdata_4), .busy(busy_4)
  );

  // Memory models; read data is garbage except in the cycle it is due.
  logic [31:0] mem0 [0:63];
  logic [31:0] mem4 [0:63];
  logic [31:0] rd0;
  logic [31:0] rd4 [0:3];

  always @(posedge clk) begin
    rd0 <= mem_rstrb ? mem0[mem_addr[5:0]] : 32'hBAD0_0000;
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) mem0[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end
  assign mem_rdata = rd0;

  always @(posedge clk) begin
    rd4[0] <= mem_rstrb_4 ? mem4[mem_addr_4[5:0]] : 32'hBAD0_0004;
    rd4[1] <= rd4[0];
    rd4[2] <= rd4[1];
    rd4[3] <= rd4[2];
  end
  assign mem_rdata_4 = rd4[3];

  // Scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] m_i_rdata, m_d_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_done"},    32'(i_done),    32'd0);
    chk({tag, "_d_done"},    32'(d_done),    32'd0);
    chk({tag, "_mem_rstrb"}, 32'(mem_rstrb), 32'd0);
    chk({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_i_rdata"},   i_rdata,        32'd0);
    chk({tag, "_d_rdata"},   d_rdata,        32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
  endtask

  typedef struct {
    bit          is_d;
    logic [5:0]  addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  // One transaction on the LATENCY=1 instance; req set in IDLE cycle T,
  // negedge k observes cycle T+k.
  task automatic run_txn(input vec_t v);
    int  done_at, rstrb_cnt, other_done;
    bit  is_w;
    is_w = v.is_d && (v.wmask != 4'd0);
    done_at = 0; rstrb_cnt = 0; other_done = 0;
    if (v.is_d) begin
      d_addr = AW'(v.addr); d_wmask = v.wmask; d_wdata = v.wdata; d_req = 1'b1;
    end else begin
      i_addr = AW'(v.addr); i_req = 1'b1;
    end
    for (int k = 1; k <= 10 && done_at == 0; k++) begin
      @(negedge clk);
      if (mem_rstrb) rstrb_cnt++;
      chk("txn_busy", 32'(busy), 32'd1);
      if (k == 1) begin
        chk("issue_addr", 32'(mem_addr), 32'(v.addr));
        chk("issue_wmask", 32'(mem_wmask), is_w ? 32'(v.wmask) : 32'd0);
        chk("issue_rstrb", 32'(mem_rstrb), is_w ? 32'd0 : 32'd1);
        if (is_w) chk("issue_wdata", mem_wdata, v.wdata);
      end
      if (v.is_d ? i_done : d_done) other_done++;
      if (v.is_d ? d_done : i_done) begin
        done_at = k;
        if (!is_w) begin
          if (v.is_d) m_d_rdata = v.exp_rdata;
          else        m_i_rdata = v.exp_rdata;
        end
        chk("done_i_rdata", i_rdata, m_i_rdata);
        chk("done_d_rdata", d_rdata, m_d_rdata);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("done_latency", 32'(done_at), 32'(v.exp_lat));
    chk("other_done", 32'(other_done), 32'd0);
    @(negedge clk);
    if (mem_rstrb) rstrb_cnt++;
    chk("done_pulse_end", {30'd0, i_done, d_done}, 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("rstrb_count", 32'(rstrb_cnt), is_w ? 32'd0 : 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_i_rdata = 32'd0;
    m_d_rdata = 32'd0;
  endtask

  initial begin
    // fetch 5; write 7 lo bytes; read 7; write 9 hi byte; fetch 9; read 12; write 12; fetch 12
    vecs[0] = '{1'b0, 6'd5,  4'b0000, 32'h0,          32'h0010_0093, 3};
    vecs[1] = '{1'b1, 6'd7,  4'b0011, 32'hDEAD_BEEF,  32'h0,         2};
    vecs[2] = '{1'b1, 6'd7,  4'b0000, 32'h0,          32'h1122_BEEF, 3};
    vecs[3] = '{1'b1, 6'd9,  4'b1000, 32'h7700_0000,  32'h0,         2};
    vecs[4] = '{1'b0, 6'd9,  4'b0000, 32'h0,          32'h77A5_A5A5, 3};
    vecs[5] = '{1'b1, 6'd12, 4'b0000, 32'h0,          32'hCAFE_F00D, 3};
    vecs[6] = '{1'b1, 6'd12, 4'b1111, 32'h0123_4567,  32'h0,         2};
    vecs[7] = '{1'b0, 6'd12, 4'b0000, 32'h0,          32'h0123_4567, 3};

    for (int a = 0; a < 64; a++) begin
      mem0[a] = 32'h0;
      mem4[a] = 32'h0;
    end
    mem0[5]  = 32'h0010_0093;
    mem0[7]  = 32'h1122_3344;
    mem0[9]  = 32'hA5A5_A5A5;
    mem0[12] = 32'hCAFE_F00D;
    mem4[3]  = 32'h1357_9BDF;

    resetn = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0; d_wmask = 4'd0; d_wdata = 32'd0;
    i_req_4 = 1'b0; i_addr_4 = '0; d_req_4 = 1'b0; d_addr_4 = '0; d_wmask_4 = 4'd0; d_wdata_4 = 32'd0;
    m_i_rdata = 32'd0;
    m_d_rdata = 32'd0;

    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_busy4", 32'(busy_4), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 8; n++) run_txn(vecs[n]);

    // Fetch request dropped during WAIT still completes, with a single access.
    begin
      int done_at, rstrb_cnt;
      done_at = 0; rstrb_cnt = 0;
      i_addr = AW'(12); i_req = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (mem_rstrb) rstrb_cnt++;
        if (k == 2) i_req = 1'b0;
        if (i_done && done_at == 0) begin
          done_at = k;
          chk("drop_rdata", i_rdata, 32'h0123_4567);
        end
      end
      chk("drop_done_at", 32'(done_at), 32'd3);
      chk("drop_rstrb_count", 32'(rstrb_cnt), 32'd1);
      chk("drop_busy", 32'(busy), 32'd0);
      m_i_rdata = 32'h0123_4567;
    end

    // Tie after reset: both held high, grants go fetch, data, fetch, data.
    pulse_reset();
    begin
      bit exp_d [4];
      exp_d[0] = 1'b0; exp_d[1] = 1'b1; exp_d[2] = 1'b0; exp_d[3] = 1'b1;
      i_addr = AW'(5); d_addr = AW'(7); d_wmask = 4'd0;
      i_req = 1'b1; d_req = 1'b1;
      for (int n = 0; n < 4; n++) begin
        bit got;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
          @(negedge clk);
          if (i_done || d_done) begin
            got = 1'b1;
            chk("tie_grant_is_data", 32'(d_done), 32'(exp_d[n]));
            chk("tie_single_done", 32'(i_done & d_done), 32'd0);
            if (d_done) chk("tie_d_rdata", d_rdata, 32'h1122_BEEF);
            else        chk("tie_i_rdata", i_rdata, 32'h0010_0093);
          end
        end
        chk("tie_done_seen", 32'(got), 32'd1);
      end
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("tie_idle_busy", 32'(busy), 32'd0);
    end

    // Async reset while the fetch read sits in WAIT.
    begin
      int stray;
      stray = 0;
      i_addr = AW'(5); i_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_busy_before", 32'(busy), 32'd1);
      resetn = 1'b0;
      #1;
      chk_all_zero("midrst");
      i_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (i_done || d_done) stray++;
      end
      resetn = 1'b1;
      m_i_rdata = 32'd0;
      m_d_rdata = 32'd0;
      @(negedge clk);
      if (i_done || d_done) stray++;
      chk("midrst_no_done", 32'(stray), 32'd0);
      run_txn(vecs[0]);
    end

    // LATENCY=4 data read: busy T+1..T+6, done at T+6.
    begin
      int done_at, done_cnt, rstrb_cnt;
      done_at = 0; done_cnt = 0; rstrb_cnt = 0;
      d_addr_4 = AW'(3); d_wmask_4 = 4'd0; d_req_4 = 1'b1;
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        if (mem_rstrb_4) rstrb_cnt++;
        chk("lat4_busy", 32'(busy_4), (k <= 6) ? 32'd1 : 32'd0);
        if (d_done_4) begin
          done_cnt++;
          if (done_at == 0) begin
            done_at = k;
            chk("lat4_rdata", d_rdata_4, 32'h1357_9BDF);
          end
          d_req_4 = 1'b0;
        end
        chk("lat4_no_i_done", 32'(i_done_4), 32'd0);
      end
      d_req_4 = 1'b0;
      chk("lat4_done_at", 32'(done_at), 32'd6);
      chk("lat4_done_cnt", 32'(done_cnt), 32'd1);
      chk("lat4_rstrb_cnt", 32'(rstrb_cnt), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Multi-cycle arbiter and sequencer for the single synchronous word memory of the RISC-V SOC. It shares the memory between the CPU instruction-fetch port and the load/store data port. It grants one requester at a time, round-robin on ties, and drives the memory strobes for that access. It waits out the configurable memory read latency and returns the read word with a one-cycle done pulse.

## Interface
- ADDR_W, 30 — word-address width (byte address bits [31:2]).
- LATENCY, 1 — memory read latency in cycles, legal range 1..15.

- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high with i_addr stable until i_done.
- i_addr  in  ADDR_W  fetch word address.
- i_rdata  out  32  fetched word, valid while i_done=1, held until next fetch completes.
- i_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held high with d_addr/d_wmask/d_wdata stable until d_done.
- d_addr  in  ADDR_W  data word address.
- d_wmask  in  4  byte write enables; 0 = read, nonzero = write.
- d_wdata  in  32  write data.
- d_rdata  out  32  loaded word, valid while d_done=1, unchanged by writes.
- d_done  out  1  one-cycle completion pulse for data.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_wmask  out  4  memory byte write enables.
- mem_rstrb  out  1  memory read strobe.
- mem_rdata  in  32  memory read data.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: no request leaves the block in IDLE. One request grants that port. Both requesting grants the port not granted most recently, tracked by the last_grant register. Go to ISSUE.
- ISSUE, exactly one cycle:
  - mem_addr is the granted address.
  - For a read, mem_rstrb=1.
  - For a write, mem_wmask=d_wmask and mem_wdata=d_wdata.
  - A fetch is always a read.
  - A write goes to DONE. A read loads the wait counter with LATENCY-1 and goes to WAIT.
- WAIT: the counter decrements each cycle. When the counter is 0, mem_rdata is captured into the granted port's rdata register and the state goes to DONE. WAIT therefore lasts LATENCY cycles.
- DONE, exactly one cycle: the granted port's done=1, then return to IDLE. The req inputs are ignored in DONE.
- The requester drops req on the edge it sees done. A req still high in the IDLE cycle after DONE is a new transaction.
- All outputs are registered.
- Outside ISSUE, mem_rstrb=0 and mem_wmask=0. mem_addr and mem_wdata hold their last values.
- If req drops mid-transaction, the access still completes and done still pulses. The other port is never granted until the current transaction completes.
- last_grant updates on grant only.

## Timing
- Reset (async, immediate):
  - state=IDLE.
  - i_done, d_done, mem_rstrb, mem_wmask, busy = 0.
  - i_rdata, d_rdata, mem_addr, mem_wdata = 0.
  - last_grant=DATA, so fetch wins the first tie.
- Reset mid-transaction aborts the transaction with no done pulse. The requester must re-request.
- Request first seen high in IDLE cycle T:
  - ISSUE in T+1.
  - Read: done in T+2+LATENCY; LATENCY=1 gives done at T+3.
  - Write: done in T+2.
- Back-to-back traffic from one port: a new grant is possible in the IDLE cycle after DONE. The read throughput limit is one access per LATENCY+3 cycles.
- Both ports continuously requesting: grants strictly alternate.
- mem_rdata is sampled only at the end of the last WAIT cycle.
- The counter is 4 bits; LATENCY=15 gives 15 WAIT cycles with no wrap.

## Test plan
- Fetch read, LATENCY=1: mem[5]=0x00100093, i_req with i_addr=5 at T. Required:
  - mem_rstrb=1 and mem_addr=5 at T+1 only.
  - i_done=1 and i_rdata=0x00100093 at T+3.
  - d_done stays 0.
- Data write: d_addr=7, d_wmask=4'b0011, d_wdata=0xDEADBEEF. Required:
  - mem_wmask=0011 and mem_wdata=0xDEADBEEF at T+1.
  - d_done at T+2.
  - d_rdata unchanged.
- Tie after reset: i_req and d_req both rise at the same cycle and stay high, re-asserted after each done. Required grant order: fetch, data, fetch, data.
- LATENCY=4 read: d_req read at T. Required: WAIT for 4 cycles, d_done at T+6, and busy high from T+1 through T+6.
- Async reset mid-read: assert resetn=0 during WAIT. Required:
  - All outputs 0 immediately.
  - No done pulse.
  - After release, a fresh i_req completes normally.
- Protocol edge: drop i_req during WAIT. Required: i_done still pulses and no second access is issued.
